// File: rtl/fp_issue_ctrl.sv
// FP issue/writeback controller: classifies decoded FP ops, starts fma/fdiv/misc
// sub-units, tracks in-flight results and arbitrates the single writeback port.

package fp_issue_ctrl_pkg;

  typedef struct packed {
    logic fmadd;
    logic fmsub;
    logic fnmadd;
    logic fnmsub;
    logic fadd;
    logic fsub;
    logic fmul;
    logic fdiv;
    logic fsqrt;
    logic fsgnj;
    logic fsgnjn;
    logic fsgnjx;
    logic fmin;
    logic fmax;
    logic feq;
    logic flt;
    logic fle;
    logic fclass;
    logic fmv;
    logic fcvt;
  } fp_operation_type;

  localparam fp_operation_type FP_FMA_MASK = '{fmadd: 1'b1, fmsub: 1'b1, fnmadd: 1'b1,
                                               fnmsub: 1'b1, fadd: 1'b1, fsub: 1'b1,
                                               fmul: 1'b1, default: 1'b0};
  localparam fp_operation_type FP_DIV_MASK = '{fdiv: 1'b1, fsqrt: 1'b1, default: 1'b0};

endpackage

module fp_issue_ctrl
  import fp_issue_ctrl_pkg::*;
#(
  parameter int unsigned FMA_LAT = 3,
  parameter int unsigned TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             req_valid_i,
  input  logic [19:0]      req_op_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             req_ready_o,
  output logic             fma_start_o,
  output logic             div_start_o,
  input  logic             div_done_i,
  output logic             div_ack_o,
  output logic             div_kill_o,
  output logic             misc_start_o,
  output logic             wb_valid_o,
  output logic [1:0]       wb_sel_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic             busy_o
);

  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  div_state_e       state_q, state_d;
  logic [TAG_W-1:0] div_tag_q, div_tag_d;
  logic [FMA_LAT-1:0] fma_vld_q, fma_vld_d;
  logic [TAG_W-1:0] fma_tag_q [FMA_LAT];
  logic [TAG_W-1:0] fma_tag_d [FMA_LAT];

  logic is_fma, is_div, is_misc, fma_cmp, accept;

  // Priority decode: FMA over DIV over MISC; all-zero op falls into MISC
  assign is_fma  = |(req_op_i & FP_FMA_MASK);
  assign is_div  = !is_fma && (|(req_op_i & FP_DIV_MASK));
  assign is_misc = !is_fma && !is_div;
  assign fma_cmp = fma_vld_q[FMA_LAT-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_tag_q <= '0;
      fma_vld_q <= '0;
      for (int i = 0; i < int'(FMA_LAT); i++) fma_tag_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      div_tag_q <= div_tag_d;
      fma_vld_q <= fma_vld_d;
      for (int i = 0; i < int'(FMA_LAT); i++) fma_tag_q[i] <= fma_tag_d[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    div_tag_d    = div_tag_q;
    req_ready_o  = 1'b0;
    fma_start_o  = 1'b0;
    div_start_o  = 1'b0;
    misc_start_o = 1'b0;
    div_ack_o    = 1'b0;
    div_kill_o   = 1'b0;
    wb_valid_o   = 1'b0;
    wb_sel_o     = SEL_W'(0);
    wb_tag_o     = '0;
    accept       = 1'b0;

    if (!flush_i) begin
      req_ready_o = is_fma
                 || (is_div && state_q == S_IDLE)
                 || (is_misc && !fma_cmp && state_q != S_DONE);
    end
    accept       = req_valid_i && req_ready_o;
    fma_start_o  = accept && is_fma;
    div_start_o  = accept && is_div;
    misc_start_o = accept && is_misc;

    // Writeback arbitration: FMA retire, then held div result, then misc issue
    if (!flush_i) begin
      if (fma_cmp) begin
        wb_valid_o = 1'b1;
        wb_sel_o   = SEL_W'(1);
        wb_tag_o   = fma_tag_q[FMA_LAT-1];
      end else if (state_q == S_DONE) begin
        wb_valid_o = 1'b1;
        wb_sel_o   = SEL_W'(2);
        wb_tag_o   = div_tag_q;
        div_ack_o  = 1'b1;
      end else if (misc_start_o) begin
        wb_valid_o = 1'b1;
        wb_sel_o   = SEL_W'(0);
        wb_tag_o   = req_tag_i;
      end
    end

    case (state_q)
      S_IDLE: if (div_start_o) begin
        state_d   = S_BUSY;
        div_tag_d = req_tag_i;
      end
      S_BUSY: if (div_done_i) state_d = S_DONE;
      S_DONE: if (div_ack_o) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      div_kill_o = (state_q != S_IDLE);
      state_d    = S_IDLE;
    end

    // FMA result tracker: slot 0 loads on issue, last slot is the retiring one
    fma_vld_d    = '0;
    fma_vld_d[0] = fma_start_o;
    fma_tag_d[0] = req_tag_i;
    for (int i = 1; i < int'(FMA_LAT); i++) begin
      fma_vld_d[i] = fma_vld_q[i-1];
      fma_tag_d[i] = fma_tag_q[i-1];
    end
    if (flush_i) fma_vld_d = '0;
  end

  assign busy_o = (|fma_vld_q) || (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed bench for fp_issue_ctrl (FMA_LAT=3, TAG_W=5) with hand-computed expectations.

module tb_fp_issue_ctrl;

  localparam int unsigned TAG_W = 5;

  // Op encodings: fmadd is bit 19 down to fcvt at bit 0
  localparam logic [19:0] OP_FMADD = 20'h80000;
  localparam logic [19:0] OP_FADD  = 20'h08000;
  localparam logic [19:0] OP_FMUL  = 20'h02000;
  localparam logic [19:0] OP_FDIV  = 20'h01000;
  localparam logic [19:0] OP_FSQRT = 20'h00800;
  localparam logic [19:0] OP_FEQ   = 20'h00020;
  localparam logic [19:0] OP_ZERO  = 20'h00000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush_i;
  logic             req_valid_i;
  logic [19:0]      req_op_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             req_ready_o;
  logic             fma_start_o;
  logic             div_start_o;
  logic             div_done_i;
  logic             div_ack_o;
  logic             div_kill_o;
  logic             misc_start_o;
  logic             wb_valid_o;
  logic [1:0]       wb_sel_o;
  logic [TAG_W-1:0] wb_tag_o;
  logic             busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  fp_issue_ctrl #(.FMA_LAT(3), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .req_valid_i  (req_valid_i),
    .req_op_i     (req_op_i),
    .req_tag_i    (req_tag_i),
    .req_ready_o  (req_ready_o),
    .fma_start_o  (fma_start_o),
    .div_start_o  (div_start_o),
    .div_done_i   (div_done_i),
    .div_ack_o    (div_ack_o),
    .div_kill_o   (div_kill_o),
    .misc_start_o (misc_start_o),
    .wb_valid_o   (wb_valid_o),
    .wb_sel_o     (wb_sel_o),
    .wb_tag_o     (wb_tag_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [19:0] op, input logic [TAG_W-1:0] tag);
    req_valid_i = v;
    req_op_i    = op;
    req_tag_i   = tag;
  endtask

  task automatic check_wb(input string tag, input logic v, input logic [1:0] sel,
                          input logic [TAG_W-1:0] t);
    check_eq({tag, "_wb_valid"}, 32'(wb_valid_o), 32'(v));
    if (v) begin
      check_eq({tag, "_wb_sel"}, 32'(wb_sel_o), 32'(sel));
      check_eq({tag, "_wb_tag"}, 32'(wb_tag_o), 32'(t));
    end
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; div_done_i = 1'b0;
    req(1'b0, OP_ZERO, '0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check_eq("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check_eq("rst_busy",     32'(busy_o),     32'd0);
    check_eq("rst_ack",      32'(div_ack_o),  32'd0);
    check_eq("rst_kill",     32'(div_kill_o), 32'd0);
    check_eq("rst_sel",      32'(wb_sel_o),   32'd0);
    check_eq("rst_tag",      32'(wb_tag_o),   32'd0);
    check_eq("rst_ready",    32'(req_ready_o), 32'd1);

    // FMA tag 7: writeback exactly three cycles later
    tick(); req(1'b1, OP_FMADD, 5'd7); #1;
    check_eq("fma_start", 32'(fma_start_o), 32'd1);
    check_eq("fma_ready", 32'(req_ready_o), 32'd1);
    check_wb("fma_t0", 1'b0, 2'd0, 5'd0);
    tick(); req(1'b0, OP_ZERO, '0); #1;
    check_wb("fma_t1", 1'b0, 2'd0, 5'd0);
    check_eq("fma_busy_t1", 32'(busy_o), 32'd1);
    tick(); #1;
    check_wb("fma_t2", 1'b0, 2'd0, 5'd0);
    check_eq("fma_busy_t2", 32'(busy_o), 32'd1);
    tick(); #1;
    check_wb("fma_t3", 1'b1, 2'd1, 5'd7);
    check_eq("fma_busy_t3", 32'(busy_o), 32'd1);
    tick(); #1;
    check_wb("fma_t4", 1'b0, 2'd0, 5'd0);
    check_eq("fma_busy_t4", 32'(busy_o), 32'd0);

    // MISC blocked by FMA retire, accepted next cycle
    tick(); req(1'b1, OP_FMUL, 5'd1); #1;
    check_eq("fm_fma_start", 32'(fma_start_o), 32'd1);
    tick(); req(1'b0, OP_ZERO, '0);
    tick();
    tick(); req(1'b1, OP_FEQ, 5'd2); #1;
    check_eq("misc_blk_ready", 32'(req_ready_o), 32'd0);
    check_eq("misc_blk_start", 32'(misc_start_o), 32'd0);
    check_wb("misc_blk", 1'b1, 2'd1, 5'd1);
    tick(); #1;
    check_eq("misc_acc_ready", 32'(req_ready_o), 32'd1);
    check_eq("misc_acc_start", 32'(misc_start_o), 32'd1);
    check_wb("misc_acc", 1'b1, 2'd0, 5'd2);

    // DIV tag 4, done at t5, FMA retiring at t6 takes priority
    tick(); req(1'b1, OP_FDIV, 5'd4); #1;
    check_eq("div_start", 32'(div_start_o), 32'd1);
    tick(); req(1'b0, OP_ZERO, '0); #1;
    check_eq("div_busy", 32'(busy_o), 32'd1);
    tick();
    tick(); req(1'b1, OP_FMADD, 5'd9); #1;
    check_eq("div_fma_start", 32'(fma_start_o), 32'd1);
    tick(); req(1'b0, OP_ZERO, '0);
    tick(); div_done_i = 1'b1; #1;
    check_wb("div_t5", 1'b0, 2'd0, 5'd0);
    check_eq("div_t5_ack", 32'(div_ack_o), 32'd0);
    tick(); #1;
    check_wb("div_t6", 1'b1, 2'd1, 5'd9);
    check_eq("div_t6_ack", 32'(div_ack_o), 32'd0);
    tick(); req(1'b1, OP_FSQRT, 5'd5); #1;
    check_wb("div_t7", 1'b1, 2'd2, 5'd4);
    check_eq("div_t7_ack", 32'(div_ack_o), 32'd1);
    check_eq("div2_ready_t7", 32'(req_ready_o), 32'd0);
    check_eq("div2_start_t7", 32'(div_start_o), 32'd0);
    tick(); div_done_i = 1'b0; #1;
    check_eq("div2_ready_t8", 32'(req_ready_o), 32'd1);
    check_eq("div2_start_t8", 32'(div_start_o), 32'd1);

    // Flush with DIV busy and two FMAs in flight
    tick(); req(1'b1, OP_FADD, 5'd10);
    tick(); req(1'b1, OP_FADD, 5'd11); #1;
    check_eq("pre_flush_busy", 32'(busy_o), 32'd1);
    tick(); flush_i = 1'b1; req(1'b1, OP_FMADD, 5'd12); #1;
    check_eq("flush_kill",  32'(div_kill_o), 32'd1);
    check_eq("flush_ready", 32'(req_ready_o), 32'd0);
    check_eq("flush_start", 32'(fma_start_o), 32'd0);
    check_wb("flush_t0", 1'b0, 2'd0, 5'd0);
    tick(); flush_i = 1'b0; req(1'b0, OP_ZERO, '0); #1;
    check_eq("flush_busy_t1", 32'(busy_o), 32'd0);
    check_eq("flush_kill_t1", 32'(div_kill_o), 32'd0);
    check_wb("flush_t1", 1'b0, 2'd0, 5'd0);
    tick(); #1;
    check_wb("flush_t2", 1'b0, 2'd0, 5'd0);
    tick(); #1;
    check_wb("flush_t3", 1'b0, 2'd0, 5'd0);

    // div_done_i coinciding with flush is lost
    tick(); req(1'b1, OP_FSQRT, 5'd3); #1;
    check_eq("dfl_start", 32'(div_start_o), 32'd1);
    tick(); req(1'b0, OP_ZERO, '0);
    tick(); div_done_i = 1'b1; flush_i = 1'b1; #1;
    check_eq("dfl_kill", 32'(div_kill_o), 32'd1);
    check_eq("dfl_ack",  32'(div_ack_o), 32'd0);
    check_wb("dfl_t0", 1'b0, 2'd0, 5'd0);
    tick(); flush_i = 1'b0; #1;
    check_eq("dfl_busy_t1", 32'(busy_o), 32'd0);
    check_eq("dfl_ack_t1",  32'(div_ack_o), 32'd0);
    check_wb("dfl_t1", 1'b0, 2'd0, 5'd0);
    tick(); div_done_i = 1'b0; #1;
    check_eq("dfl_busy_t2", 32'(busy_o), 32'd0);
    check_wb("dfl_t2", 1'b0, 2'd0, 5'd0);

    // All-zero op is MISC
    tick(); req(1'b1, OP_ZERO, 5'd12); #1;
    check_eq("zero_misc_start", 32'(misc_start_o), 32'd1);
    check_wb("zero_misc", 1'b1, 2'd0, 5'd12);

    // Multi-hot priority, then reset with FMA and DIV in flight
    tick(); req(1'b1, OP_FADD | OP_FDIV, 5'd6); #1;
    check_eq("mh_fma_start", 32'(fma_start_o), 32'd1);
    check_eq("mh_div_start", 32'(div_start_o), 32'd0);
    tick(); req(1'b1, OP_FDIV | OP_FEQ, 5'd8); #1;
    check_eq("mh2_div_start",  32'(div_start_o), 32'd1);
    check_eq("mh2_misc_start", 32'(misc_start_o), 32'd0);
    tick(); req(1'b0, OP_ZERO, '0); rst_n = 1'b0;
    tick(); rst_n = 1'b1; #1;
    check_wb("mrst_t0", 1'b0, 2'd0, 5'd0);
    check_eq("mrst_busy", 32'(busy_o), 32'd0);
    check_eq("mrst_kill", 32'(div_kill_o), 32'd0);
    check_eq("mrst_ack",  32'(div_ack_o), 32'd0);
    tick(); #1;
    check_wb("mrst_t1", 1'b0, 2'd0, 5'd0);
    tick(); #1;
    check_wb("mrst_t2", 1'b0, 2'd0, 5'd0);
    check_eq("mrst_busy_t2", 32'(busy_o), 32'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
